dtcm_ctrl: RTL and testbench

Upstream access controller for the data TCM. Accepts byte/half/word load-store commands from the LSU over a valid/ready handshake and converts each into one dtcm_ram access: word address, replicated write data and byte write-enable mask. Formats the synchronous read data (lane select, sign/zero extension) into a valid/ready response with backpressure. Sits between the LSU and dtcm_ram.

---
 rtl/dtcm_ctrl_pkg.sv | 35 +++
 rtl/dtcm_ctrl_if.sv | 24 ++
 rtl/dtcm_ld_fmt.sv | 27 ++
 rtl/dtcm_ctrl.sv | 139 +++++++++++++
 tb/tb_dtcm_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtcm_ctrl_pkg.sv
// Shared types, size encodings and store-lane helpers for the data TCM controller.
// RAM word-address width defaults to 10.
package dtcm_ctrl_pkg;

  localparam int RAM_AW_DEF = 10;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  function automatic logic [MW-1:0] st_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_SIZE_B: return 4'b0001 << off;
      LSU_SIZE_H: return 4'b0011 << {off[1], 1'b0};
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [DW-1:0] st_data(input logic [1:0] size, input logic [DW-1:0] wdata);
    case (size)
      LSU_SIZE_B: return {4{wdata[7:0]}};
      LSU_SIZE_H: return {2{wdata[15:0]}};
      default:    return wdata;
    endcase
  endfunction

endpackage

// File: rtl/dtcm_ctrl_if.sv
// LSU-side command/response handshake bundle of the data TCM controller.
interface dtcm_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic        cmd_unsigned;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_size, cmd_unsigned, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_size, cmd_unsigned, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dtcm_ld_fmt.sv
// Load formatter: picks the byte/half lane of a RAM word and sign/zero extends it.
module dtcm_ld_fmt
  import dtcm_ctrl_pkg::*;
(
  input  logic [DW-1:0] dout,
  input  logic [1:0]    off,
  input  logic [1:0]    size,
  input  logic          uns,
  output logic [DW-1:0] data
);

  logic [DW-1:0] shifted;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  always_comb begin
    shifted = dout >> {off, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = off[1] ? dout[31:16] : dout[15:0];
    case (size)
      LSU_SIZE_B: data = {{24{lane_b[7] & ~uns}}, lane_b};
      LSU_SIZE_H: data = {{16{lane_h[15] & ~uns}}, lane_h};
      default:    data = dout;
    endcase
  end

endmodule

// File: rtl/dtcm_ctrl.sv
// Data TCM access controller: LSU load/store commands to dtcm_ram accesses and formatted responses.
// Misaligned half/word accesses are flagged as errors when DTCM_MISALIGN_CHK_EN is defined.
module dtcm_ctrl
  import dtcm_ctrl_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  dtcm_ctrl_if.slave        lsu,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_din,
  output logic [MW-1:0]     ram_wem,
  input  logic [DW-1:0]     ram_dout
);

  state_t              state;
  logic                lat_read;
  logic                lat_uns;
  logic                lat_err;
  logic [1:0]          lat_size;
  logic [1:0]          lat_off;
  logic [RAM_AW-1:0]   addr_q;
  logic [DW-1:0]       hold_data;
  logic                hold_err;
  logic [DW-1:0]       fmt_data;
  logic [DW-1:0]       data_now;
  logic                accept;
  logic                cmd_misalign;
  logic [1:0]          cmd_off;
  logic                unused_addr;

  assign unused_addr = ^lsu.cmd_addr[31:RAM_AW+2];

  // Without the check, misaligned low bits are dropped so the access aligns down.
  always_comb begin
    cmd_misalign = 1'b0;
    cmd_off      = lsu.cmd_addr[1:0];
    case (lsu.cmd_size)
      LSU_SIZE_B: ;
      LSU_SIZE_H: begin
`ifdef DTCM_MISALIGN_CHK_EN
        cmd_misalign = lsu.cmd_addr[0];
`else
        cmd_off[0] = 1'b0;
`endif
      end
      default: begin
`ifdef DTCM_MISALIGN_CHK_EN
        cmd_misalign = |lsu.cmd_addr[1:0];
`else
        cmd_off = 2'b00;
`endif
      end
    endcase
  end

  // Gated by rst so nothing is accepted, and no write issued, while reset is held.
  assign lsu.cmd_ready = ~rst & ((state == ST_IDLE) | ((state == ST_DATA) & lsu.rsp_ready));
  assign accept        = lsu.cmd_valid & lsu.cmd_ready;

  assign ram_we   = accept & ~lsu.cmd_read & ~cmd_misalign;
  assign ram_addr = accept ? lsu.cmd_addr[RAM_AW+1:2] : addr_q;
  assign ram_din  = st_data(lsu.cmd_size, lsu.cmd_wdata);
  assign ram_wem  = ram_we ? st_mask(lsu.cmd_size, cmd_off) : '0;

  dtcm_ld_fmt u_ld_fmt (
    .dout (ram_dout),
    .off  (lat_off),
    .size (lat_size),
    .uns  (lat_uns),
    .data (fmt_data)
  );

  assign data_now = (lat_read & ~lat_err) ? fmt_data : '0;

  always_comb begin
    lsu.rsp_valid = 1'b0;
    lsu.rsp_rdata = '0;
    lsu.rsp_err   = 1'b0;
    case (state)
      ST_DATA: begin
        lsu.rsp_valid = 1'b1;
        lsu.rsp_rdata = data_now;
        lsu.rsp_err   = lat_err;
      end
      ST_HOLD: begin
        lsu.rsp_valid = 1'b1;
        lsu.rsp_rdata = hold_data;
        lsu.rsp_err   = hold_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_read  <= 1'b0;
      lat_uns   <= 1'b0;
      lat_err   <= 1'b0;
      lat_size  <= 2'b00;
      lat_off   <= 2'b00;
      addr_q    <= '0;
      hold_data <= '0;
      hold_err  <= 1'b0;
    end else begin
      if (accept) begin
        lat_read <= lsu.cmd_read;
        lat_uns  <= lsu.cmd_unsigned;
        lat_err  <= cmd_misalign;
        lat_size <= lsu.cmd_size;
        lat_off  <= cmd_off;
        addr_q   <= lsu.cmd_addr[RAM_AW+1:2];
      end
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_DATA;
        end
        ST_DATA: begin
          if (lsu.rsp_ready) begin
            state <= lsu.cmd_valid ? ST_DATA : ST_IDLE;
          end else begin
            // RAM output is only valid this cycle, so freeze the formatted word.
            hold_data <= data_now;
            hold_err  <= lat_err;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (lsu.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Directed scoreboard bench for dtcm_ctrl with a behavioural dtcm_ram and byte-level shadow memory.
module tb_dtcm_ctrl;

  logic        clk;
  logic        rst;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [3:0]  ram_wem;
  logic [31:0] ram_dout;

  dtcm_ctrl_if lsu ();

  dtcm_ctrl #(.RAM_AW(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .lsu      (lsu.slave),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_wem  (ram_wem),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_wem[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
    ram_dout <= mem[ram_addr];
  end

  logic [7:0]  smem [0:4095];
  logic [32:0] sbq [$];
  int          checks;
  int          passes;
  int          rsp_cnt;
  logic        acc_prev;
  logic [31:0] held;
  int          r0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic tb_misal(input logic [31:0] a, input logic [1:0] sz);
    logic m;
    m = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`ifdef DTCM_MISALIGN_CHK_EN
    return m;
`else
    return m & 1'b0;
`endif
  endfunction

  function automatic logic [11:0] tb_ea(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b01) return {a[11:1], 1'b0};
    if (sz[1]) return {a[11:2], 2'b00};
    return a[11:0];
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input logic un);
    logic [11:0] ea;
    logic [7:0]  b;
    logic [15:0] h;
    ea = tb_ea(a, sz);
    b  = smem[ea];
    h  = {smem[ea+12'd1], smem[ea]};
    if (sz == 2'b00) return un ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01) return un ? {16'h0, h} : {{16{h[15]}}, h};
    return {smem[ea+12'd3], smem[ea+12'd2], smem[ea+12'd1], smem[ea]};
  endfunction

  // Called once per cycle just after the falling edge.
  task automatic monitor();
    logic [32:0] e;
    logic        err;
    logic [11:0] ea;
    if (rst) begin
      acc_prev = 1'b0;
      return;
    end
    if (acc_prev) chk("rsp_latency", {31'h0, lsu.rsp_valid}, 32'h1);
    if (lsu.rsp_valid && lsu.rsp_ready) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 32'(sbq.size()), 32'h1);
      end else begin
        e = sbq.pop_front();
        chk("rsp_rdata", lsu.rsp_rdata, e[31:0]);
        chk("rsp_err", {31'h0, lsu.rsp_err}, {31'h0, e[32]});
        rsp_cnt++;
      end
    end
    acc_prev = lsu.cmd_valid && lsu.cmd_ready;
    if (acc_prev) begin
      err = tb_misal(lsu.cmd_addr, lsu.cmd_size);
      if (lsu.cmd_read && !err)
        sbq.push_back({1'b0, exp_load(lsu.cmd_addr, lsu.cmd_size, lsu.cmd_unsigned)});
      else
        sbq.push_back({err, 32'h0});
      if (!lsu.cmd_read && !err) begin
        ea = tb_ea(lsu.cmd_addr, lsu.cmd_size);
        smem[ea] = lsu.cmd_wdata[7:0];
        if (lsu.cmd_size != 2'b00) smem[ea+12'd1] = lsu.cmd_wdata[15:8];
        if (lsu.cmd_size[1]) begin
          smem[ea+12'd2] = lsu.cmd_wdata[23:16];
          smem[ea+12'd3] = lsu.cmd_wdata[31:24];
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic cmd(input logic v, input logic rd, input logic [31:0] a, input logic [1:0] sz,
                     input logic un, input logic [31:0] wd);
    lsu.cmd_valid    = v;
    lsu.cmd_read     = rd;
    lsu.cmd_addr     = a;
    lsu.cmd_size     = sz;
    lsu.cmd_unsigned = un;
    lsu.cmd_wdata    = wd;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cmd(1'b0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h0);
      sample();
      adv();
    end
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    rsp_cnt  = 0;
    acc_prev = 1'b0;
    rst      = 1'b1;
    lsu.rsp_ready = 1'b0;
    cmd(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    #1;
    chk("rst_rsp_valid", {31'h0, lsu.rsp_valid}, 32'h0);
    chk("rst_cmd_ready", {31'h0, lsu.cmd_ready}, 32'h0);
    chk("rst_ram_we",    {31'h0, ram_we}, 32'h0);
    chk("rst_ram_wem",   {28'h0, ram_wem}, 32'h0);
    chk("rst_rsp_err",   {31'h0, lsu.rsp_err}, 32'h0);
    chk("rst_rsp_rdata", lsu.rsp_rdata, 32'h0);
    adv();
    rst = 1'b0;
    lsu.rsp_ready = 1'b1;
    sample();
    chk("idle_cmd_ready", {31'h0, lsu.cmd_ready}, 32'h1);
    adv();

    // word store then word load
    cmd(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
    sample();
    chk("sw_we",   {31'h0, ram_we}, 32'h1);
    chk("sw_wem",  {28'h0, ram_wem}, 32'hF);
    chk("sw_addr", {22'h0, ram_addr}, 32'h4);
    chk("sw_din",  ram_din, 32'hDEADBEEF);
    adv();
    cmd(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0);
    sample();
    chk("lw_we", {31'h0, ram_we}, 32'h0);
    adv();
    cmd(1'b0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h0);
    sample();
    chk("lw_rdata", lsu.rsp_rdata, 32'hDEADBEEF);
    adv();
    idle_cycles(1);

    // byte store, signed and unsigned byte loads
    cmd(1'b1, 1'b0, 32'h13, 2'b00, 1'b0, 32'h00000080);
    sample();
    chk("sb_wem",  {28'h0, ram_wem}, 32'h8);
    chk("sb_din",  ram_din, 32'h80808080);
    chk("sb_addr", {22'h0, ram_addr}, 32'h4);
    adv();
    cmd(1'b1, 1'b1, 32'h13, 2'b00, 1'b0, 32'h0);
    sample();
    adv();
    cmd(1'b1, 1'b1, 32'h13, 2'b00, 1'b1, 32'h0);
    sample();
    chk("lb_signed", lsu.rsp_rdata, 32'hFFFFFF80);
    adv();
    cmd(1'b0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h0);
    sample();
    chk("lbu", lsu.rsp_rdata, 32'h00000080);
    adv();

    // half store, signed half load
    cmd(1'b1, 1'b0, 32'h22, 2'b01, 1'b0, 32'h00008001);
    sample();
    chk("sh_wem",  {28'h0, ram_wem}, 32'hC);
    chk("sh_din",  ram_din, 32'h80018001);
    chk("sh_addr", {22'h0, ram_addr}, 32'h8);
    adv();
    cmd(1'b1, 1'b1, 32'h22, 2'b01, 1'b0, 32'h0);
    sample();
    adv();
    cmd(1'b0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h0);
    sample();
    chk("lh_signed", lsu.rsp_rdata, 32'hFFFF8001);
    adv();
    idle_cycles(1);

    // back-to-back loads, then backpressure into HOLD
    r0 = rsp_cnt;
    cmd(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0); sample(); adv();
    cmd(1'b1, 1'b1, 32'h13, 2'b00, 1'b1, 32'h0); sample(); adv();
    cmd(1'b1, 1'b1, 32'h22, 2'b01, 1'b0, 32'h0); sample(); adv();
    cmd(1'b1, 1'b1, 32'h10, 2'b00, 1'b0, 32'h0); sample(); adv();
    cmd(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0);
    sample();
    chk("b2b_count", 32'(rsp_cnt - r0), 32'h4);
    adv();
    cmd(1'b1, 1'b1, 32'h22, 2'b01, 1'b1, 32'h0);
    lsu.rsp_ready = 1'b0;
    sample();
    held = lsu.rsp_rdata;
    chk("data_rdata", held, 32'h80ADBEEF);
    chk("data_cmd_ready", {31'h0, lsu.cmd_ready}, 32'h0);
    adv();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("hold_valid", {31'h0, lsu.rsp_valid}, 32'h1);
      chk("hold_cmd_ready", {31'h0, lsu.cmd_ready}, 32'h0);
      chk("hold_rdata", lsu.rsp_rdata, 32'h80ADBEEF);
      adv();
    end
    lsu.rsp_ready = 1'b1;
    sample();
    adv();
    sample();
    adv();
    cmd(1'b0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h0);
    sample();
    chk("hold_drain_rdata", lsu.rsp_rdata, 32'h00008001);
    adv();
    idle_cycles(1);

    // misaligned word store
    cmd(1'b1, 1'b0, 32'h11, 2'b10, 1'b0, 32'h11223344);
    sample();
`ifdef DTCM_MISALIGN_CHK_EN
    chk("mis_we", {31'h0, ram_we}, 32'h0);
    chk("mis_wem", {28'h0, ram_wem}, 32'h0);
`else
    chk("mis_we", {31'h0, ram_we}, 32'h1);
    chk("mis_wem", {28'h0, ram_wem}, 32'hF);
    chk("mis_addr", {22'h0, ram_addr}, 32'h4);
    chk("mis_din", ram_din, 32'h11223344);
`endif
    adv();
    cmd(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0);
    sample();
`ifdef DTCM_MISALIGN_CHK_EN
    chk("mis_rsp_err", {31'h0, lsu.rsp_err}, 32'h1);
`else
    chk("mis_rsp_err", {31'h0, lsu.rsp_err}, 32'h0);
`endif
    adv();
    cmd(1'b1, 1'b1, 32'h23, 2'b01, 1'b1, 32'h0);
    sample();
`ifdef DTCM_MISALIGN_CHK_EN
    chk("mis_mem", lsu.rsp_rdata, 32'h80ADBEEF);
`else
    chk("mis_mem", lsu.rsp_rdata, 32'h11223344);
`endif
    adv();
    idle_cycles(2);

    // reset while a response is stalled in DATA
    lsu.rsp_ready = 1'b0;
    cmd(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0);
    sample();
    adv();
    cmd(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h55AA55AA);
    rst = 1'b1;
    #1;
    chk("rstmid_rsp_valid", {31'h0, lsu.rsp_valid}, 32'h0);
    chk("rstmid_ram_we", {31'h0, ram_we}, 32'h0);
    sbq.delete();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rstmid_no_we", {31'h0, ram_we}, 32'h0);
      adv();
    end
    cmd(1'b0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h0);
    lsu.rsp_ready = 1'b1;
    rst = 1'b0;
    sample();
    chk("rstrel_cmd_ready", {31'h0, lsu.cmd_ready}, 32'h1);
    chk("rstrel_rsp_valid", {31'h0, lsu.rsp_valid}, 32'h0);
    adv();
    cmd(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0);
    sample();
    adv();
    idle_cycles(3);
    chk("sb_empty", 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
